// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte producers.
// Issues a one-cycle trigger per granted byte and tracks the UART busy/complete handshake.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned BUSY_TIMEOUT = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic [NUM_REQ-1:0]   req_valid_i,
    input  logic [8*NUM_REQ-1:0] req_data_i,
    output logic [NUM_REQ-1:0]   req_ready_o,
    output logic [NUM_REQ-1:0]   grant_o,
    output logic [7:0]           tx_data_o,
    output logic                 tx_trigger_o,
    input  logic                 tx_complete_i,
    output logic                 busy_o,
    output logic                 timeout_o
);

    localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CntW = $clog2(BUSY_TIMEOUT);
    localparam logic [PtrW-1:0] PtrInit = PtrW'(NUM_REQ - 1);
    localparam logic [CntW-1:0] CntLast = CntW'(BUSY_TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StWaitBusy, StWaitDone} state_e;

    state_e               state_q, state_d;
    logic [PtrW-1:0]      ptr_q, ptr_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [NUM_REQ-1:0]   ready_q, ready_d;
    logic [7:0]           data_q, data_d;
    logic                 trig_q, trig_d;
    logic                 busy_q, busy_d;
    logic                 tout_q, tout_d;

    logic                 win_found;
    logic [PtrW-1:0]      win_idx;
    logic [PtrW-1:0]      cand;
    logic [NUM_REQ-1:0]   win_onehot;
    logic                 accept;
    logic                 expire;

    // Search upward from the slot after the last winner, wrapping around.
    always_comb begin
        win_found = 1'b0;
        win_idx   = ptr_q;
        cand      = ptr_q;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            cand = PtrW'((int'(ptr_q) + 1 + i) % int'(NUM_REQ));
            if (!win_found && req_valid_i[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign win_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx;
    assign accept     = (state_q == StIdle) && win_found && tx_complete_i;
    assign expire     = (state_q == StWaitBusy) && tx_complete_i && (cnt_q == CntLast);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= StIdle;
            ptr_q   <= PtrInit;
            cnt_q   <= '0;
            grant_q <= '0;
            ready_q <= '0;
            data_q  <= 8'h00;
            trig_q  <= 1'b0;
            busy_q  <= 1'b0;
            tout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            ready_q <= ready_d;
            data_q  <= data_d;
            trig_q  <= trig_d;
            busy_q  <= busy_d;
            tout_q  <= tout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StWaitBusy;
                    ptr_d   = win_idx;
                    cnt_d   = '0;
                end
            end
            StWaitBusy: begin
                if (!tx_complete_i) begin
                    state_d = StWaitDone;
                    cnt_d   = '0;
                end else if (cnt_q == CntLast) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StWaitDone: begin
                if (tx_complete_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Next values of the registered outputs; the byte is latched only on accept.
    always_comb begin
        grant_d = grant_q;
        data_d  = data_q;
        ready_d = '0;
        trig_d  = 1'b0;
        tout_d  = 1'b0;
        if (accept) begin
            grant_d = win_onehot;
            ready_d = win_onehot;
            data_d  = req_data_i[32'(win_idx)*8 +: 8];
            trig_d  = 1'b1;
        end
        if (expire) begin
            tout_d  = 1'b1;
            grant_d = '0;
        end
        if ((state_q == StWaitDone) && tx_complete_i) begin
            grant_d = '0;
        end
        busy_d = (state_d != StIdle);
    end

    assign req_ready_o  = ready_q;
    assign grant_o      = grant_q;
    assign tx_data_o    = data_q;
    assign tx_trigger_o = trig_q;
    assign busy_o       = busy_q;
    assign timeout_o    = tout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: cycle vectors with hand-computed outputs, then timeout,
// mid-byte reset and round-robin sequences against a simple UART model.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic [3:0]  grant;
    logic [7:0]  tx_data;
    logic        tx_trigger;
    logic        tx_complete;
    logic        busy;
    logic        timeout;

    int n_cmp = 0;
    int n_err = 0;

    bit uart_auto = 1'b0;
    int uart_busy = 0;
    bit trig_prev = 1'b0;

    localparam logic [31:0] D0 = 32'hA3A2A1A0;
    localparam logic [31:0] DX = 32'h5A5A5A5A;

    uart_tx_arbiter #(.NUM_REQ(4), .BUSY_TIMEOUT(16)) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .req_valid_i  (req_valid),
        .req_data_i   (req_data),
        .req_ready_o  (req_ready),
        .grant_o      (grant),
        .tx_data_o    (tx_data),
        .tx_trigger_o (tx_trigger),
        .tx_complete_i(tx_complete),
        .busy_o       (busy),
        .timeout_o    (timeout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  valid;
        logic [31:0] data;
        logic        cpl;
        logic        trig;
        logic [3:0]  ready;
        logic [3:0]  grant;
        logic [7:0]  txd;
        logic        busy;
        logic        tout;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic [3:0] v, input logic [31:0] d, input logic c,
                       input logic t, input logic [3:0] r, input logic [3:0] g,
                       input logic [7:0] x, input logic b, input logic o);
        vec_t e;
        e = '{v, d, c, t, r, g, x, b, o};
        vq.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Advance one clock and sample 1 time unit after the edge; the UART model
    // drops complete for 10 cycles after it captures a trigger.
    task automatic tick();
        @(posedge clk);
        #1;
        if (uart_auto) begin
            if (uart_busy > 0) begin
                uart_busy--;
                if (uart_busy == 0) tx_complete = 1'b1;
            end
            if (trig_prev) begin
                tx_complete = 1'b0;
                uart_busy   = 10;
            end
            trig_prev = tx_trigger;
        end
    endtask

    task automatic chk_all0(input string tag);
        chk({tag, " ready"}, 32'(req_ready), 0);
        chk({tag, " grant"}, 32'(grant), 0);
        chk({tag, " data"}, 32'(tx_data), 0);
        chk({tag, " trig"}, 32'(tx_trigger), 0);
        chk({tag, " busy"}, 32'(busy), 0);
        chk({tag, " tout"}, 32'(timeout), 0);
    endtask

    initial begin
        int ntrig;
        bit prev_trig;

        // valid data cpl | trig ready grant txd busy tout
        add(4'b1111, D0, 1, 1, 4'b0001, 4'b0001, 8'hA0, 1, 0);
        add(4'b1110, D0, 0, 0, 4'b0000, 4'b0001, 8'hA0, 1, 0);
        add(4'b1110, D0, 0, 0, 4'b0000, 4'b0001, 8'hA0, 1, 0);
        add(4'b1110, D0, 1, 0, 4'b0000, 4'b0000, 8'hA0, 0, 0);
        add(4'b0010, D0, 0, 0, 4'b0000, 4'b0000, 8'hA0, 0, 0);
        add(4'b0010, D0, 0, 0, 4'b0000, 4'b0000, 8'hA0, 0, 0);
        add(4'b0010, D0, 1, 1, 4'b0010, 4'b0010, 8'hA1, 1, 0);
        add(4'b0000, D0, 0, 0, 4'b0000, 4'b0010, 8'hA1, 1, 0);
        add(4'b0000, D0, 1, 0, 4'b0000, 4'b0000, 8'hA1, 0, 0);
        add(4'b0100, D0, 1, 1, 4'b0100, 4'b0100, 8'hA2, 1, 0);
        add(4'b0011, D0, 0, 0, 4'b0000, 4'b0100, 8'hA2, 1, 0);
        add(4'b0011, D0, 1, 0, 4'b0000, 4'b0000, 8'hA2, 0, 0);
        add(4'b0011, D0, 1, 1, 4'b0001, 4'b0001, 8'hA0, 1, 0);
        add(4'b1010, DX, 0, 0, 4'b0000, 4'b0001, 8'hA0, 1, 0);
        add(4'b1010, DX, 1, 0, 4'b0000, 4'b0000, 8'hA0, 0, 0);
        add(4'b1010, D0, 1, 1, 4'b0010, 4'b0010, 8'hA1, 1, 0);
        add(4'b1001, D0, 0, 0, 4'b0000, 4'b0010, 8'hA1, 1, 0);
        add(4'b1001, D0, 1, 0, 4'b0000, 4'b0000, 8'hA1, 0, 0);
        add(4'b1001, D0, 1, 1, 4'b1000, 4'b1000, 8'hA3, 1, 0);
        add(4'b0001, D0, 0, 0, 4'b0000, 4'b1000, 8'hA3, 1, 0);
        add(4'b0001, D0, 1, 0, 4'b0000, 4'b0000, 8'hA3, 0, 0);
        add(4'b0001, D0, 1, 1, 4'b0001, 4'b0001, 8'hA0, 1, 0);
        add(4'b0000, D0, 0, 0, 4'b0000, 4'b0001, 8'hA0, 1, 0);
        add(4'b0000, D0, 1, 0, 4'b0000, 4'b0000, 8'hA0, 0, 0);

        // Reset held with requests pending
        rst_n       = 1'b0;
        req_valid   = 4'b1111;
        req_data    = D0;
        tx_complete = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_all0("reset");
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vq[i]) begin
            req_valid   = vq[i].valid;
            req_data    = vq[i].data;
            tx_complete = vq[i].cpl;
            tick();
            chk($sformatf("vec%0d trig", i), 32'(tx_trigger), 32'(vq[i].trig));
            chk($sformatf("vec%0d ready", i), 32'(req_ready), 32'(vq[i].ready));
            chk($sformatf("vec%0d grant", i), 32'(grant), 32'(vq[i].grant));
            chk($sformatf("vec%0d data", i), 32'(tx_data), 32'(vq[i].txd));
            chk($sformatf("vec%0d busy", i), 32'(busy), 32'(vq[i].busy));
            chk($sformatf("vec%0d tout", i), 32'(timeout), 32'(vq[i].tout));
        end

        // Timeout: UART never drops complete; pointer is at 0 so requester 1 wins
        req_valid   = 4'b0110;
        tx_complete = 1'b1;
        tick();
        chk("to trig", 32'(tx_trigger), 1);
        chk("to grant", 32'(grant), 32'b0010);
        req_valid = 4'b0100;
        for (int k = 1; k <= 16; k++) begin
            tick();
            chk($sformatf("to cyc%0d tout", k), 32'(timeout), (k == 16) ? 1 : 0);
        end
        chk("to grant cleared", 32'(grant), 0);
        chk("to busy cleared", 32'(busy), 0);
        tick();
        chk("to pulse width", 32'(timeout), 0);
        chk("to next trig", 32'(tx_trigger), 1);
        chk("to next grant", 32'(grant), 32'b0100);
        chk("to next data", 32'(tx_data), 32'hA2);

        // Reset while in WAIT_DONE
        req_valid   = 4'b0000;
        tx_complete = 1'b0;
        tick();
        chk("mid busy", 32'(busy), 1);
        chk("mid grant", 32'(grant), 32'b0100);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all0("mid reset");
        @(negedge clk);
        req_valid   = 4'b1111;
        tx_complete = 1'b1;
        rst_n       = 1'b1;
        tick();
        chk("post reset grant", 32'(grant), 32'b0001);
        chk("post reset data", 32'(tx_data), 32'hA0);

        // Round robin with the UART model, all requesters always valid
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n       = 1'b1;
        req_data    = 32'h44434241;
        req_valid   = 4'b1111;
        tx_complete = 1'b1;
        uart_auto   = 1'b1;
        uart_busy   = 0;
        trig_prev   = 1'b0;
        ntrig       = 0;
        prev_trig   = 1'b0;
        for (int c = 0; c < 300 && ntrig < 5; c++) begin
            tick();
            if (prev_trig) begin
                chk($sformatf("rr%0d ready width", ntrig), 32'(req_ready), 0);
                chk($sformatf("rr%0d trig width", ntrig), 32'(tx_trigger), 0);
            end
            prev_trig = tx_trigger;
            if (tx_trigger) begin
                chk($sformatf("rr%0d grant", ntrig), 32'(grant), 32'(1 << (ntrig % 4)));
                chk($sformatf("rr%0d ready", ntrig), 32'(req_ready), 32'(1 << (ntrig % 4)));
                chk($sformatf("rr%0d data", ntrig), 32'(tx_data), 32'h41 + 32'(ntrig % 4));
                ntrig++;
            end
        end
        chk("rr trigger count", 32'(ntrig), 5);
        uart_auto = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
